// File: rtl/io_sched_fl_pkg.sv
// rtl/io_sched_fl_pkg.sv - shared FSM state type and address-width helper for io_sched_fl
package io_sched_fl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } itr_state_t;

  // Channel-select width, never narrower than one bit so single-channel builds still have a port.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_sched_fl_rr_arb.sv
// rtl/io_sched_fl_rr_arb.sv - combinational round-robin picker: first pending index at or after ptr
module io_sched_fl_rr_arb #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  always_comb begin
    int idx;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && pend[idx]) begin
        any   = 1'b1;
        grant = W'(idx);
      end
    end
  end

endmodule

// File: rtl/io_sched_fl.sv
// rtl/io_sched_fl.sv - proc_fl I/O scheduler: per-channel word buffers, strobe decode, RR interrupt
module io_sched_fl
  import io_sched_fl_pkg::*;
#(
  parameter int  NBMANT = 16,
  parameter int  NBEXPO = 6,
  parameter int  NUIOIN = 2,
  parameter int  NUIOOU = 2,
  localparam int NBDATA = NBMANT + NBEXPO + 1,
  localparam int NAI    = addr_w(NUIOIN),
  localparam int NAO    = addr_w(NUIOOU)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [NBDATA-1:0]        proc_io_in,
  input  logic [NAI-1:0]           proc_addr_in,
  input  logic                     proc_req_in,
  input  logic [NBDATA-1:0]        proc_io_out,
  input  logic [NAO-1:0]           proc_addr_out,
  input  logic                     proc_out_en,
  output logic                     proc_itr,
  input  logic [NUIOIN-1:0]        itr_en,
  output logic [NAI-1:0]           itr_id,
  input  logic [NUIOIN*NBDATA-1:0] in_data,
  input  logic [NUIOIN-1:0]        in_vld,
  output logic [NUIOIN-1:0]        in_rdy,
  output logic [NUIOOU*NBDATA-1:0] out_data,
  output logic [NUIOOU-1:0]        out_vld,
  input  logic [NUIOOU-1:0]        out_rdy,
  output logic [NUIOOU-1:0]        ovf
);

  logic [NBDATA-1:0] in_buf [NUIOIN];
  logic [NUIOIN-1:0] full;
  logic [NUIOIN-1:0] rd;

  genvar i;
  generate
    for (i = 0; i < NUIOIN; i++) begin : g_in
      logic [NBDATA-1:0] word;
      logic              is_full;

      assign rd[i]     = proc_req_in && (proc_addr_in == NAI'(i));
      // A read in the same cycle frees the slot, so the producer may refill without a bubble.
      assign in_rdy[i] = ~is_full | rd[i];
      assign full[i]   = is_full;
      assign in_buf[i] = word;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word    <= '0;
          is_full <= 1'b0;
        end else if (in_vld[i] && in_rdy[i]) begin
          word    <= in_data[i*NBDATA +: NBDATA];
          is_full <= 1'b1;
        end else if (rd[i]) begin
          is_full <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    proc_io_in = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (proc_addr_in == NAI'(k)) proc_io_in = in_buf[k];
    end
  end

  genvar j;
  generate
    for (j = 0; j < NUIOOU; j++) begin : g_out
      logic [NBDATA-1:0] word;
      logic              vld;
      logic              lost;
      logic              wr;

      assign wr                            = proc_out_en && (proc_addr_out == NAO'(j));
      assign out_data[j*NBDATA +: NBDATA]  = word;
      assign out_vld[j]                    = vld;
      assign ovf[j]                        = lost;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word <= '0;
          vld  <= 1'b0;
          lost <= 1'b0;
        end else if (wr) begin
          word <= proc_io_out;
          vld  <= 1'b1;
          if (vld && !out_rdy[j]) lost <= 1'b1;
        end else if (vld && out_rdy[j]) begin
          vld <= 1'b0;
        end
      end
    end
  endgenerate

  itr_state_t        state, state_nxt;
  logic [NAI-1:0]    ptr;
  logic [NAI-1:0]    grant;
  logic [NUIOIN-1:0] pend;
  logic              any;
  logic              rd_hit;
  logic              en_hit;
  logic              latch_grant;
  logic              advance_ptr;

  assign pend = full & itr_en;

  io_sched_fl_rr_arb #(.N(NUIOIN), .W(NAI)) u_rr_arb (
    .pend  (pend),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    rd_hit = 1'b0;
    en_hit = 1'b0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (itr_id == NAI'(k)) begin
        rd_hit = rd[k];
        en_hit = itr_en[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any) state_nxt = ST_FIRE;
      ST_FIRE: state_nxt = ST_WAIT;
      ST_WAIT: if (rd_hit || !en_hit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    proc_itr    = (state == ST_FIRE);
    latch_grant = (state == ST_IDLE) && any;
    // Only a real service rotates priority; a masked-off wait leaves the pointer alone.
    advance_ptr = (state == ST_WAIT) && rd_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      itr_id <= '0;
      ptr    <= '0;
    end else begin
      if (latch_grant) itr_id <= grant;
      if (advance_ptr) ptr <= (int'(itr_id) == NUIOIN - 1) ? '0 : itr_id + NAI'(1);
    end
  end

endmodule

// File: tb/tb_io_sched_fl.sv
// tb/tb_io_sched_fl.sv - randomized and directed bench for io_sched_fl against a behavioural model
module tb_io_sched_fl;
  localparam int NB = 23;
  localparam int NI = 2;
  localparam int NO = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0]    proc_io_in, proc_io_out;
  logic [0:0]       proc_addr_in, proc_addr_out, itr_id;
  logic             proc_req_in, proc_out_en, proc_itr;
  logic [NI-1:0]    itr_en, in_vld, in_rdy;
  logic [NI*NB-1:0] in_data;
  logic [NO*NB-1:0] out_data;
  logic [NO-1:0]    out_vld, out_rdy, ovf;

  io_sched_fl u_dut (
    .clk(clk), .rst(rst), .proc_io_in(proc_io_in), .proc_addr_in(proc_addr_in),
    .proc_req_in(proc_req_in), .proc_io_out(proc_io_out), .proc_addr_out(proc_addr_out),
    .proc_out_en(proc_out_en), .proc_itr(proc_itr), .itr_en(itr_en), .itr_id(itr_id),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy), .out_data(out_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .ovf(ovf)
  );

  logic [NB-1:0]   d3_io_in, d3_io_out;
  logic [1:0]      d3_addr_in, d3_itr_id;
  logic [0:0]      d3_addr_out;
  logic            d3_req_in, d3_out_en, d3_itr;
  logic [2:0]      d3_itr_en, d3_in_vld, d3_in_rdy;
  logic [3*NB-1:0] d3_in_data;
  logic [2*NB-1:0] d3_out_data;
  logic [1:0]      d3_out_vld, d3_out_rdy, d3_ovf;

  io_sched_fl #(.NUIOIN(3)) u_dut3 (
    .clk(clk), .rst(rst), .proc_io_in(d3_io_in), .proc_addr_in(d3_addr_in),
    .proc_req_in(d3_req_in), .proc_io_out(d3_io_out), .proc_addr_out(d3_addr_out),
    .proc_out_en(d3_out_en), .proc_itr(d3_itr), .itr_en(d3_itr_en), .itr_id(d3_itr_id),
    .in_data(d3_in_data), .in_vld(d3_in_vld), .in_rdy(d3_in_rdy), .out_data(d3_out_data),
    .out_vld(d3_out_vld), .out_rdy(d3_out_rdy), .ovf(d3_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: buffered words, flags, and interrupt phase (0 idle, 1 pulse, 2 awaiting service).
  logic [NB-1:0] m_buf [NI];
  bit            m_full [NI];
  logic [NB-1:0] m_obuf [NO];
  bit            m_ovld [NO];
  bit            m_ovf [NO];
  int            m_phase, m_id, m_ptr;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin m_buf[i] = '0; m_full[i] = 0; end
    for (int j = 0; j < NO; j++) begin m_obuf[j] = '0; m_ovld[j] = 0; m_ovf[j] = 0; end
    m_phase = 0; m_id = 0; m_ptr = 0;
  endtask

  function automatic bit rd(input int i);
    return proc_req_in && (int'(proc_addr_in) == i);
  endfunction

  function automatic bit wr(input int j);
    return proc_out_en && (int'(proc_addr_out) == j);
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) check($sformatf("in_rdy%0d", i), 64'(in_rdy[i]), 64'(!m_full[i] || rd(i)));
    check("proc_io_in", 64'(proc_io_in), 64'(m_buf[proc_addr_in]));
    check("proc_itr", 64'(proc_itr), 64'(m_phase == 1));
    check("itr_id", 64'(itr_id), 64'(m_id));
    for (int j = 0; j < NO; j++) begin
      check($sformatf("out_vld%0d", j), 64'(out_vld[j]), 64'(m_ovld[j]));
      check($sformatf("out_data%0d", j), 64'(out_data[j*NB +: NB]), 64'(m_obuf[j]));
      check($sformatf("ovf%0d", j), 64'(ovf[j]), 64'(m_ovf[j]));
    end
  endtask

  task automatic model_step();
    bit pend [NI];
    bit found;
    int c;
    for (int i = 0; i < NI; i++) pend[i] = m_full[i] && itr_en[i];
    if (m_phase == 0) begin
      found = 0;
      for (int k = 0; k < NI; k++) begin
        c = (m_ptr + k) % NI;
        if (!found && pend[c]) begin found = 1; m_id = c; end
      end
      if (found) m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rd(m_id)) begin
      m_ptr = (m_id + 1) % NI;
      m_phase = 0;
    end else if (!itr_en[m_id]) begin
      m_phase = 0;
    end
    for (int i = 0; i < NI; i++) begin
      if (in_vld[i] && (!m_full[i] || rd(i))) begin
        m_buf[i] = in_data[i*NB +: NB];
        m_full[i] = 1;
      end else if (rd(i)) begin
        m_full[i] = 0;
      end
    end
    for (int j = 0; j < NO; j++) begin
      if (wr(j)) begin
        if (m_ovld[j] && !out_rdy[j]) m_ovf[j] = 1;
        m_obuf[j] = proc_io_out;
        m_ovld[j] = 1;
      end else if (m_ovld[j] && out_rdy[j]) begin
        m_ovld[j] = 0;
      end
    end
  endtask

  // Inputs are already driven (just after a falling edge); check, advance model, cross one rising edge.
  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    proc_req_in = 0; proc_addr_in = '0; proc_out_en = 0; proc_addr_out = '0;
    proc_io_out = '0; in_vld = '0; in_data = '0;
  endtask

  task automatic wait_pulse(input string tag, input int exp_id);
    int seen;
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      if (proc_itr) seen = 1;
      else cycle();
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_id"}, 64'(itr_id), 64'(exp_id));
  endtask

  task automatic load_in(input int ch, input logic [NB-1:0] w);
    quiet();
    in_vld[ch] = 1'b1;
    in_data[ch*NB +: NB] = w;
    cycle();
    quiet();
  endtask

  task automatic read_in(input int ch);
    quiet();
    proc_req_in = 1; proc_addr_in = 1'(ch);
    cycle();
    quiet();
  endtask

  initial begin
    int pulses;
    quiet();
    out_rdy = '1; itr_en = '0;
    d3_io_out = '0; d3_addr_in = '0; d3_addr_out = '0; d3_req_in = 0; d3_out_en = 0;
    d3_itr_en = '0; d3_in_vld = '0; d3_in_data = '0; d3_out_rdy = '1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;

    // Read and load in the same cycle: the old word is seen, the new one stays buffered.
    load_in(1, 23'h0AAAAA);
    proc_req_in = 1; proc_addr_in = 1'b1; in_vld = 2'b10; in_data[NB +: NB] = 23'h055555;
    #1 check("rdld_old", 64'(proc_io_in), 64'h0AAAAA);
    cycle();
    quiet();
    #1 check("rdld_full", 64'(in_rdy[1]), 64'd0);
    proc_addr_in = 1'b1;
    #1 check("rdld_new", 64'(proc_io_in), 64'h055555);
    quiet();

    // Output backpressure and overwrite.
    out_rdy = '0;
    proc_out_en = 1; proc_addr_out = 1'b0; proc_io_out = 23'd5; cycle();
    proc_io_out = 23'd7; cycle();
    quiet();
    #1 check("bp_data", 64'(out_data[NB-1:0]), 64'd7);
    check("bp_ovf", 64'(ovf[0]), 64'd1);
    out_rdy = '1;
    cycle();
    check("bp_drain", 64'(out_vld[0]), 64'd0);

    // Round-robin interrupts: ch1 already full, fill ch0, then enable both.
    load_in(0, 23'h000111);
    itr_en = 2'b11;
    wait_pulse("rr_first", 0);
    cycle();
    read_in(0);
    wait_pulse("rr_second", 1);
    load_in(0, 23'h000222);
    read_in(1);
    wait_pulse("rr_third", 0);
    cycle();
    read_in(0);

    // Masking: only ch0 enabled, ch1 full must stay silent; dropping enable in wait aborts.
    itr_en = 2'b01;
    load_in(1, 23'h000333);
    pulses = 0;
    for (int n = 0; n < 6; n++) begin pulses += int'(proc_itr); cycle(); end
    check("mask_silent", 64'(pulses), 64'd0);
    load_in(0, 23'h000444);
    wait_pulse("mask_ch0", 0);
    cycle();
    itr_en = 2'b00;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin pulses += int'(proc_itr); cycle(); end
    check("mask_drop", 64'(pulses), 64'd0);

    // Randomized traffic checked cycle by cycle against the model.
    itr_en = 2'b11;
    for (int n = 0; n < 600; n++) begin
      in_vld = 2'($urandom);
      in_data = {23'($urandom), 23'($urandom)};
      proc_req_in = ($urandom_range(0, 9) < 4);
      proc_addr_in = 1'($urandom);
      proc_out_en = ($urandom_range(0, 9) < 3);
      proc_addr_out = 1'($urandom);
      proc_io_out = 23'($urandom);
      out_rdy = 2'($urandom);
      if ($urandom_range(0, 39) == 0) itr_en = 2'($urandom);
      cycle();
    end

    // Asynchronous reset mid-traffic, then a first load after release.
    in_vld = 2'b11;
    #2 rst = 0;
    #1;
    check("rst_in_rdy", 64'(in_rdy), 64'b11);
    check("rst_out_vld", 64'(out_vld), 64'b00);
    check("rst_itr", 64'(proc_itr), 64'd0);
    check("rst_ovf", 64'(ovf), 64'b00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    quiet();
    itr_en = 2'b00;
    load_in(0, 23'h000123);
    #1 check("post_rst_full", 64'(in_rdy[0]), 64'd0);
    check("post_rst_word", 64'(proc_io_in), 64'h000123);

    // Three-input instance: out-of-range read returns zero and leaves the buffer alone.
    d3_in_vld = 3'b001; d3_in_data[NB-1:0] = 23'h0002AA;
    @(posedge clk); @(negedge clk);
    d3_in_vld = '0; d3_req_in = 1; d3_addr_in = 2'd3;
    #1 check("oor_zero", 64'(d3_io_in), 64'd0);
    @(posedge clk); @(negedge clk);
    d3_req_in = 0; d3_addr_in = 2'd0;
    #1 check("oor_full", 64'(d3_in_rdy[0]), 64'd0);
    check("oor_word", 64'(d3_io_in), 64'h0002AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
